// File: rtl/usr_rdarb_pkg.sv
// -----------------------------------------------------------------------------
// usr_rdarb_pkg
// Shared types and defaults for the two-requester read arbiter (usr_rdarb).
//   state_e  : arbiter FSM state (IDLE, GNT_A, GNT_B)
//   owner_e  : owner / requester ID (ID_A=0, ID_B=1)
//   *_DEF    : default values of the usr_rdarb parameters
// Helpers map a winning owner to its grant state and to the other requester.
// -----------------------------------------------------------------------------
package usr_rdarb_pkg;

  localparam int unsigned AWID_DEF = 8;  // read address width
  localparam int unsigned MIDX_DEF = 7;  // bank-select address bit
  localparam int unsigned MPND_DEF = 5;  // read data width is MPND+1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } owner_e;

  // Grant state that presents a grant to the given owner.
  function automatic state_e grant_state(input owner_e id);
    return (id == ID_B) ? GNT_B : GNT_A;
  endfunction

  // The requester that is not 'id'; used to advance the round-robin pointer.
  function automatic owner_e other_owner(input owner_e id);
    return (id == ID_A) ? ID_B : ID_A;
  endfunction

endpackage

// File: rtl/usr_rdarb_rr2.sv
// -----------------------------------------------------------------------------
// usr_rdarb_rr2
// Two-way round-robin pick. Purely combinational.
//   elig_a_i / elig_b_i : requester A / B is eligible this cycle
//   ptr_i               : requester that wins a tie
//   win_vld_o           : at least one requester is eligible
//   win_o               : winning requester (only meaningful with win_vld_o)
// -----------------------------------------------------------------------------
module usr_rdarb_rr2
  import usr_rdarb_pkg::*;
(
  input  logic   elig_a_i,
  input  logic   elig_b_i,
  input  owner_e ptr_i,
  output logic   win_vld_o,
  output owner_e win_o
);

  always_comb begin
    win_vld_o = elig_a_i | elig_b_i;
    win_o     = ID_A;
    if (elig_a_i && elig_b_i) begin
      win_o = ptr_i;
    end else if (elig_b_i) begin
      win_o = ID_B;
    end
  end

endmodule

// File: rtl/usr_rdarb.sv
// -----------------------------------------------------------------------------
// usr_rdarb
// Two-requester read arbiter in front of a two-bank memory.
// A registered FSM grants one requester per cycle (round robin on a tie),
// launches the bank read in the grant cycle (s2), tracks bank select and owner
// through s3, and returns the selected bank's data in s4 two cycles after the
// grant.
//
// Ports
//   usclk, sso_rst_n         : clock (rising edge) / async active-low reset
//   req_a, req_b             : read requests, held until their grant
//   adr_a, adr_b [AWID]      : request addresses
//   gnt_a, gnt_b             : one-cycle grant pulses
//   rd_en_s2, adr_s2 [AWID]  : bank read strobe / address
//   rd_dat0_s3, rd_dat1_s3   : bank 0/1 data, one cycle after rd_en_s2
//   rd_vld_s4, rd_id_s4      : return valid / owner (0=A, 1=B)
//   rd_dat_s4 [MPND+1]       : return data, held while rd_vld_s4=0
// Optional (macro USR_RDARB_PAR_EN):
//   rd_par0_s3, rd_par1_s3   : even parity of bank 0/1 data
//   rd_perr_s4               : parity error of the returned read
// -----------------------------------------------------------------------------
module usr_rdarb
  import usr_rdarb_pkg::*;
#(
  parameter int unsigned AWID = AWID_DEF,
  parameter int unsigned MIDX = MIDX_DEF,
  parameter int unsigned MPND = MPND_DEF
) (
  input  logic            usclk,
  input  logic            sso_rst_n,
  input  logic            req_a,
  input  logic            req_b,
  input  logic [AWID-1:0] adr_a,
  input  logic [AWID-1:0] adr_b,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic            rd_en_s2,
  output logic [AWID-1:0] adr_s2,
  input  logic [MPND:0]   rd_dat0_s3,
  input  logic [MPND:0]   rd_dat1_s3,
`ifdef USR_RDARB_PAR_EN
  input  logic            rd_par0_s3,
  input  logic            rd_par1_s3,
  output logic            rd_perr_s4,
`endif
  output logic            rd_vld_s4,
  output logic            rd_id_s4,
  output logic [MPND:0]   rd_dat_s4
);

  // ---------------------------------------------------------------------------
  // Arbitration (s2)
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  owner_e          ptr_q, ptr_d;
  logic [AWID-1:0] adr_s2_q, adr_s2_d;
  owner_e          id_s2;
  logic            elig_a, elig_b;
  logic            win_vld;
  owner_e          win;

  // The requester shown a grant this cycle still holds its old request, so it
  // is masked out; otherwise a held req would be granted twice.
  assign elig_a = req_a & (state_q != GNT_A);
  assign elig_b = req_b & (state_q != GNT_B);

  usr_rdarb_rr2 u_rr2 (
    .elig_a_i  (elig_a),
    .elig_b_i  (elig_b),
    .ptr_i     (ptr_q),
    .win_vld_o (win_vld),
    .win_o     (win)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    state_d  = IDLE;
    ptr_d    = ptr_q;
    adr_s2_d = adr_s2_q;
    if (win_vld) begin
      state_d  = grant_state(win);
      ptr_d    = other_owner(win);   // point at the one not granted
      adr_s2_d = (win == ID_B) ? adr_b : adr_a;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge usclk or negedge sso_rst_n) begin
    if (!sso_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= ID_A;
      adr_s2_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      adr_s2_q <= adr_s2_d;
    end
  end

  // Grants and the read strobe decode straight from the registered state.
  assign gnt_a    = (state_q == GNT_A);
  assign gnt_b    = (state_q == GNT_B);
  assign rd_en_s2 = (state_q != IDLE);
  assign adr_s2   = adr_s2_q;
  assign id_s2    = (state_q == GNT_B) ? ID_B : ID_A;

  // ---------------------------------------------------------------------------
  // s3: bank select, owner and valid travel alongside the bank access
  // ---------------------------------------------------------------------------
  logic   sel_s3_q;
  owner_e id_s3_q;
  logic   vld_s3_q;

  always_ff @(posedge usclk or negedge sso_rst_n) begin
    if (!sso_rst_n) begin
      sel_s3_q <= 1'b0;
      id_s3_q  <= ID_A;
      vld_s3_q <= 1'b0;
    end else begin
      sel_s3_q <= adr_s2_q[MIDX];
      id_s3_q  <= id_s2;
      vld_s3_q <= rd_en_s2;
    end
  end

  logic [MPND:0] dat_sel_s3;
  assign dat_sel_s3 = sel_s3_q ? rd_dat1_s3 : rd_dat0_s3;

  // ---------------------------------------------------------------------------
  // s4: return registers
  // ---------------------------------------------------------------------------
  logic          rd_vld_s4_q;
  owner_e        rd_id_s4_q;
  logic [MPND:0] rd_dat_s4_q;

  // NOTE: the data/owner return registers are reset too, because every
  // output must read 0 while reset is held; outside reset they only load
  // with a valid return and otherwise hold.
  always_ff @(posedge usclk or negedge sso_rst_n) begin
    if (!sso_rst_n) begin
      rd_vld_s4_q <= 1'b0;
      rd_id_s4_q  <= ID_A;
      rd_dat_s4_q <= '0;
    end else begin
      rd_vld_s4_q <= vld_s3_q;
      if (vld_s3_q) begin
        rd_id_s4_q  <= id_s3_q;
        rd_dat_s4_q <= dat_sel_s3;
      end
    end
  end

  assign rd_vld_s4 = rd_vld_s4_q;
  assign rd_id_s4  = rd_id_s4_q;
  assign rd_dat_s4 = rd_dat_s4_q;

`ifdef USR_RDARB_PAR_EN
  // ---------------------------------------------------------------------------
  // Optional parity check of the selected bank (even parity: data ^ par == 0)
  // ---------------------------------------------------------------------------
  logic par_sel_s3;
  logic rd_perr_s4_q;

  assign par_sel_s3 = sel_s3_q ? rd_par1_s3 : rd_par0_s3;

  always_ff @(posedge usclk or negedge sso_rst_n) begin
    if (!sso_rst_n) begin
      rd_perr_s4_q <= 1'b0;
    end else begin
      rd_perr_s4_q <= vld_s3_q & ((^dat_sel_s3) ^ par_sel_s3);
    end
  end

  assign rd_perr_s4 = rd_perr_s4_q;
`endif

endmodule

// File: doc/usr_rdarb.md
USR_RDARB -- requirements
Module: usr_rdarb

Interface
REQ-001 The block SHALL have parameter AWID, default 8, giving the read address width.
REQ-002 The block SHALL have parameter MIDX, default 7, giving the bank-select address bit (0 <= MIDX < AWID).
REQ-003 The block SHALL have parameter MPND, default 5; read data width is MPND+1.
REQ-004 Port usclk, input, 1: the only clock; all state is rising-edge.
REQ-005 Port sso_rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports req_a/req_b, input, 1 each: read request from requester A/B.
REQ-007 Ports adr_a/adr_b, input, AWID each: request address.
REQ-008 Ports gnt_a/gnt_b, output, 1 each: one-cycle grant pulse.
REQ-009 Port rd_en_s2, output, 1: bank read strobe.
REQ-010 Port adr_s2, output, AWID: bank read address.
REQ-011 Ports rd_dat0_s3/rd_dat1_s3, input, MPND+1 each: bank 0/1 data, valid one cycle after rd_en_s2.
REQ-012 Port rd_vld_s4, output, 1: return data valid.
REQ-013 Port rd_id_s4, output, 1: return owner, 0=A, 1=B.
REQ-014 Port rd_dat_s4, output, MPND+1: return data.

Function
REQ-015 Requesters SHALL hold req_x and adr_x stable until gnt_x; req_x is deasserted or a new request is presented the cycle after gnt_x.
REQ-016 The FSM SHALL have states IDLE, GNT_A and GNT_B; the state is registered, and gnt_a=(state==GNT_A), gnt_b=(state==GNT_B).
REQ-017 From any state, the next state SHALL be GNT_x for the single eligible requester, the round-robin winner if both are eligible, else IDLE.
REQ-018 A requester granted in cycle t SHALL be ineligible in cycle t (mask of the current state's owner), so no double grant occurs on a held req.
REQ-019 Round-robin pointer SHALL point to the requester not most recently granted, updating only on a grant; on a tie the pointed requester wins.
REQ-020 In the cycle a grant is asserted, rd_en_s2 SHALL be 1 and adr_s2 SHALL carry the granted requester's address, registered at the grant decision.
REQ-021 Stage s3 SHALL register sel_s3=adr_s2[MIDX], id_s3 and vld_s3=rd_en_s2.
REQ-022 Stage s4 SHALL register rd_dat_s4 = sel_s3==0 ? rd_dat0_s3 : rd_dat1_s3, with rd_id_s4=id_s3 and rd_vld_s4=vld_s3.
REQ-023 Latency SHALL be fixed: rd_vld_s4 occurs 2 cycles after the matching gnt; throughput is 1 read per cycle when both requesters alternate.
REQ-024 While rd_vld_s4=0, rd_dat_s4 and rd_id_s4 SHALL hold their previous values.
REQ-025 A single requester held continuously SHALL be granted every other cycle.

Reset
REQ-026 While sso_rst_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE and the pointer SHALL be A.
REQ-027 Reset mid-operation SHALL discard in-flight s2/s3 reads with no rd_vld_s4 after release.
REQ-028 The first grant after reset deassertion SHALL occur no earlier than the first rising edge with reset high.

Configuration
REQ-029 With USR_RDARB_PAR_EN defined, the block SHALL add inputs rd_par0_s3/rd_par1_s3 (1 bit, even parity over bank data) and output rd_perr_s4, set with rd_vld_s4 on mismatch of the selected bank and 0 otherwise.
REQ-030 Without USR_RDARB_PAR_EN, those ports and their logic SHALL be absent.

Structure
REQ-031 Package usr_rdarb_pkg SHALL hold the FSM state enum, the owner ID enum (ID_A=0, ID_B=1) and the default parameter values.
REQ-032 The two-way round-robin pick (eligibles plus pointer in, winner out) SHALL be sub-module usr_rdarb_rr2.

Verification
REQ-033 Reset with req_a=req_b=1 -> all outputs 0 during reset; gnt_a on first post-reset edge (pointer=A).
REQ-034 req_a and req_b held, adr_a=8'h05, adr_b=8'h85 -> gnt sequence A,B,A,B; rd_dat_s4 alternates rd_dat0_s3/rd_dat1_s3 with rd_id_s4 0,1.
REQ-035 Only req_b held, adr_b=8'h80 -> gnt_b every other cycle; rd_vld_s4 exactly 2 cycles after each gnt_b, with data from bank 1.
REQ-036 sso_rst_n pulled low one cycle after gnt_a -> no rd_vld_s4 for that read after release.
REQ-037 With USR_RDARB_PAR_EN defined, bank 0 data 6'h07 with rd_par0_s3=0 -> rd_perr_s4=1 with rd_vld_s4.
REQ-038 Idle for 10 cycles -> rd_en_s2, gnt_a, gnt_b and rd_vld_s4 remain 0; rd_dat_s4 holds its last value.
